alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one external ALU between two requesters (A and B). A request is
// accepted in IDLE, its operands and control code are captured, the ALU is
// driven for a number of EXEC cycles that depends on the operation, and the
// result is handed back with a one-cycle done pulse to the requester that
// was granted. Ties are resolved round-robin, with A favoured after reset.
// Divide-by-zero and undefined control codes never reach the ALU; they
// complete immediately with an error.
//
// Ports
//   clk, reset_n            clock (rising edge), async active-low reset
//   req_a/req_b             level requests, held until granted
//   a_op1/a_op2/a_ctrl      operands and control code from requester A
//   b_op1/b_op2/b_ctrl      operands and control code from requester B
//   gnt_a/gnt_b             one-cycle pulse: request accepted
//   done_a/done_b           one-cycle pulse: result valid for that requester
//   result/sign/err         captured result, sign flag and error status
//   busy                    high whenever the block is not in IDLE
//   alu_op1/alu_op2/alu_ctrl  operands and code driven to the shared ALU
//   alu_data_in/alu_sign_in   ALU result and sign flag
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int MUL_WAIT = 2,
  parameter int DIV_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_a,
  input  logic        req_b,
  input  logic [16:0] a_op1,
  input  logic [16:0] a_op2,
  input  logic [16:0] b_op1,
  input  logic [16:0] b_op2,
  input  logic [3:0]  a_ctrl,
  input  logic [3:0]  b_ctrl,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic        done_a,
  output logic        done_b,
  output logic [32:0] result,
  output logic        sign,
  output logic        err,
  output logic        busy,
  output logic [16:0] alu_op1,
  output logic [16:0] alu_op2,
  output logic [3:0]  alu_ctrl,
  input  logic [32:0] alu_data_in,
  input  logic        alu_sign_in
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t      r_state;
  state_t      w_nextState;

  logic        r_lastB;
  logic        r_ownerB;
  logic [16:0] r_op1;
  logic [16:0] r_op2;
  logic [3:0]  r_ctrl;
  logic [7:0]  r_count;
  logic [32:0] r_result;
  logic        r_sign;
  logic        r_err;

  logic        w_grantA;
  logic        w_grantB;
  logic        w_grant;
  logic [16:0] w_selOp1;
  logic [16:0] w_selOp2;
  logic [3:0]  w_selCtrl;
  logic        w_bypass;
  logic [7:0]  w_waitLoad;
  logic        w_lastExec;

  // Arbitration. Grants are only offered in IDLE and are masked while reset
  // is asserted so that every output reads 0 during reset. On a tie, the
  // requester that was not granted last wins (r_lastB set means B went last,
  // so A wins).
  always_comb begin
    w_grantA = 1'b0;
    w_grantB = 1'b0;
    if (r_state == IDLE && reset_n) begin
      if (req_a && req_b) begin
        w_grantA = r_lastB;
        w_grantB = ~r_lastB;
      end else begin
        w_grantA = req_a;
        w_grantB = req_b;
      end
    end
  end

  assign w_grant   = w_grantA | w_grantB;
  assign w_selOp1  = w_grantB ? b_op1  : a_op1;
  assign w_selOp2  = w_grantB ? b_op2  : a_op2;
  assign w_selCtrl = w_grantB ? b_ctrl : a_ctrl;

  // Undefined codes and divide-by-zero skip EXEC so the ALU never sees them.
  assign w_bypass = (w_selCtrl > 4'd8) ||
                    (w_selCtrl == 4'b0010 && w_selOp2 == 17'd0);

  // Number of EXEC cycles for the operation being granted.
  always_comb begin
    case (w_selCtrl)
      4'b0010: w_waitLoad = 8'(DIV_WAIT);
      4'b0011: w_waitLoad = 8'(MUL_WAIT);
      default: w_waitLoad = 8'd1;
    endcase
  end

  // The "<=" guards against a zero load ever trapping the FSM in EXEC.
  assign w_lastExec = (r_state == EXEC) && (r_count <= 8'd1);

  // State register; reset drops straight back to IDLE, abandoning any
  // operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and output decode. The ALU is only driven with live operands
  // in EXEC; everywhere else it sees the idle code 1111 with zero operands.
  always_comb begin
    w_nextState = r_state;
    gnt_a       = 1'b0;
    gnt_b       = 1'b0;
    done_a      = 1'b0;
    done_b      = 1'b0;
    alu_op1     = 17'd0;
    alu_op2     = 17'd0;
    alu_ctrl    = 4'b1111;
    case (r_state)
      IDLE: begin
        gnt_a = w_grantA;
        gnt_b = w_grantB;
        if (w_grant) begin
          w_nextState = w_bypass ? DONE : EXEC;
        end
      end
      EXEC: begin
        alu_op1  = r_op1;
        alu_op2  = r_op2;
        alu_ctrl = r_ctrl;
        if (w_lastExec) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        done_a      = ~r_ownerB;
        done_b      = r_ownerB;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Operand capture, wait counter and result registers. Bypassed operations
  // write their error result at grant time; normal operations capture the
  // ALU output on the last EXEC cycle. The sign flag is only meaningful for
  // add and subtract.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lastB  <= 1'b1;
      r_ownerB <= 1'b0;
      r_op1    <= 17'd0;
      r_op2    <= 17'd0;
      r_ctrl   <= 4'd0;
      r_count  <= 8'd0;
      r_result <= 33'd0;
      r_sign   <= 1'b0;
      r_err    <= 1'b0;
    end else if (w_grant) begin
      r_ownerB <= w_grantB;
      r_lastB  <= w_grantB;
      r_op1    <= w_selOp1;
      r_op2    <= w_selOp2;
      r_ctrl   <= w_selCtrl;
      r_count  <= w_waitLoad;
      if (w_bypass) begin
        r_result <= 33'd0;
        r_sign   <= 1'b0;
        r_err    <= 1'b1;
      end
    end else if (r_state == EXEC) begin
      r_count <= r_count - 8'd1;
      if (w_lastExec) begin
        r_result <= alu_data_in;
        r_sign   <= (r_ctrl == 4'b0000 || r_ctrl == 4'b0001) ? alu_sign_in : 1'b0;
        r_err    <= 1'b0;
      end
    end
  end

  assign result = r_result;
  assign sign   = r_sign;
  assign err    = r_err;
  assign busy   = (r_state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Self-checking bench for alu_arbiter. The shared ALU is modelled here as a
// plain arithmetic function of the operands the DUT drives. Expected results
// for the directed table are hand-written constants; random transactions are
// checked against a reference model that works from the operation rules
// (bypass conditions, wait lengths, round-robin by last winner).
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int MulWait = 2;
  localparam int DivWait = 4;

  logic        clk;
  logic        reset_n;
  logic        req_a;
  logic        req_b;
  logic [16:0] a_op1;
  logic [16:0] a_op2;
  logic [16:0] b_op1;
  logic [16:0] b_op2;
  logic [3:0]  a_ctrl;
  logic [3:0]  b_ctrl;
  logic        gnt_a;
  logic        gnt_b;
  logic        done_a;
  logic        done_b;
  logic [32:0] result;
  logic        sign;
  logic        err;
  logic        busy;
  logic [16:0] alu_op1;
  logic [16:0] alu_op2;
  logic [3:0]  alu_ctrl;
  logic [32:0] alu_data_in;
  logic        alu_sign_in;

  int checks = 0;
  int errors = 0;
  bit lastGrantB = 1'b1;

  typedef struct {
    string       name;
    bit          useB;
    logic [16:0] op1;
    logic [16:0] op2;
    logic [3:0]  ctrl;
    int          expN;
    logic [32:0] expRes;
    bit          expSign;
    bit          expErr;
  } vec_t;

  vec_t vecs[12];

  alu_arbiter #(
    .MUL_WAIT(MulWait),
    .DIV_WAIT(DivWait)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_a      (req_a),
    .req_b      (req_b),
    .a_op1      (a_op1),
    .a_op2      (a_op2),
    .b_op1      (b_op1),
    .b_op2      (b_op2),
    .a_ctrl     (a_ctrl),
    .b_ctrl     (b_ctrl),
    .gnt_a      (gnt_a),
    .gnt_b      (gnt_b),
    .done_a     (done_a),
    .done_b     (done_b),
    .result     (result),
    .sign       (sign),
    .err        (err),
    .busy       (busy),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_ctrl   (alu_ctrl),
    .alu_data_in(alu_data_in),
    .alu_sign_in(alu_sign_in)
  );

  // External ALU: signed arithmetic on sign-extended operands.
  function automatic logic [32:0] aluModel(input logic [16:0] o1, input logic [16:0] o2,
                                           input logic [3:0] c);
    logic signed [32:0] a;
    logic signed [32:0] b;
    logic signed [32:0] r;
    a = {{16{o1[16]}}, o1};
    b = {{16{o2[16]}}, o2};
    case (c)
      4'b0000: r = a + b;
      4'b0001: r = a - b;
      4'b0010: r = (b == 33'sd0) ? 33'sd0 : a / b;
      4'b0011: r = a * b;
      4'b0100: r = a & b;
      4'b0101: r = a | b;
      4'b0110: r = a ^ b;
      4'b0111: r = a <<< 1;
      4'b1000: r = ~a;
      default: r = 33'sd0;
    endcase
    return r;
  endfunction

  assign alu_data_in = aluModel(alu_op1, alu_op2, alu_ctrl);
  assign alu_sign_in = alu_data_in[32];

  // Reference model: what a transaction should produce.
  function automatic void refModel(input logic [16:0] o1, input logic [16:0] o2,
                                   input logic [3:0] c, output int n,
                                   output logic [32:0] r, output bit s, output bit e);
    if (c > 4'd8 || (c == 4'd2 && o2 == 17'd0)) begin
      n = 0;
      r = 33'd0;
      s = 1'b0;
      e = 1'b1;
    end else begin
      n = (c == 4'd2) ? DivWait : (c == 4'd3) ? MulWait : 1;
      r = aluModel(o1, o2, c);
      s = (c <= 4'd1) ? r[32] : 1'b0;
      e = 1'b0;
    end
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit side, input logic [16:0] o1, input logic [16:0] o2,
                               input logic [3:0] c);
    if (side) begin
      b_op1  = o1;
      b_op2  = o2;
      b_ctrl = c;
      req_b  = 1'b1;
    end else begin
      a_op1  = o1;
      a_op2  = o2;
      a_ctrl = c;
      req_a  = 1'b1;
    end
  endtask

  task automatic randomRequest(input bit side);
    logic [16:0] o2;
    o2 = ($urandom_range(0, 3) == 0) ? 17'd0 : 17'($urandom);
    applyStimulus(side, 17'($urandom), o2, 4'($urandom_range(0, 15)));
  endtask

  // Runs one transaction from an IDLE cycle with requests already driven
  // (called just after a rising edge). Ends just after the rising edge that
  // follows the done pulse.
  task automatic runTransaction(input string tag, input bit expB, input int expN,
                                input logic [16:0] expOp1, input logic [16:0] expOp2,
                                input logic [3:0] expCtrl, input logic [32:0] expRes,
                                input bit expSign, input bit expErr);
    bit seenDone;
    seenDone = 1'b0;
    @(negedge clk);
    checkOutput({tag, " gnt"}, 64'({gnt_a, gnt_b}), expB ? 64'd1 : 64'd2);
    @(posedge clk);
    #1;
    if (expB) req_b = 1'b0;
    else req_a = 1'b0;
    for (int cyc = 0; cyc < 40 && !seenDone; cyc++) begin
      @(negedge clk);
      if (done_a || done_b) begin
        seenDone = 1'b1;
        checkOutput({tag, " latency"}, 64'(cyc), 64'(expN));
        checkOutput({tag, " done"}, 64'({done_a, done_b}), expB ? 64'd1 : 64'd2);
        checkOutput({tag, " result"}, 64'(result), 64'(expRes));
        checkOutput({tag, " sign/err"}, 64'({sign, err}), 64'({expSign, expErr}));
        checkOutput({tag, " done bus"},
                    64'({gnt_a, gnt_b, busy, alu_ctrl, alu_op1, alu_op2}),
                    64'({2'b00, 1'b1, 4'b1111, 17'd0, 17'd0}));
      end else begin
        checkOutput({tag, " exec bus"},
                    64'({busy, gnt_a, gnt_b, alu_ctrl, alu_op1, alu_op2}),
                    64'({1'b1, 2'b00, expCtrl, expOp1, expOp2}));
      end
    end
    if (!seenDone) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: no done pulse within 40 cycles", tag);
    end
    @(posedge clk);
    #1;
    checkOutput({tag, " hold"}, 64'({busy, result, sign, err}),
                64'({1'b0, expRes, expSign, expErr}));
    lastGrantB = expB;
  endtask

  initial begin
    logic [16:0] o1;
    logic [16:0] o2;
    logic [3:0]  c;
    int          n;
    logic [32:0] r;
    bit          s;
    bit          e;
    bit          winB;

    vecs[0]  = '{"add",     1'b0, 17'd5,     17'h1FFF9, 4'b0000, 1, 33'h1FFFFFFFE, 1'b1, 1'b0};
    vecs[1]  = '{"mul",     1'b1, 17'd300,   17'd200,   4'b0011, 2, 33'd60000,     1'b0, 1'b0};
    vecs[2]  = '{"div0",    1'b0, 17'd9,     17'd0,     4'b0010, 0, 33'd0,         1'b0, 1'b1};
    vecs[3]  = '{"illegal", 1'b0, 17'd5,     17'd3,     4'b1010, 0, 33'd0,         1'b0, 1'b1};
    vecs[4]  = '{"addclr",  1'b0, 17'd3,     17'd4,     4'b0000, 1, 33'd7,         1'b0, 1'b0};
    vecs[5]  = '{"sub",     1'b1, 17'd2,     17'd9,     4'b0001, 1, 33'h1FFFFFFF9, 1'b1, 1'b0};
    vecs[6]  = '{"div",     1'b0, 17'd100,   17'd7,     4'b0010, 4, 33'd14,        1'b0, 1'b0};
    vecs[7]  = '{"and",     1'b1, 17'd12,    17'd10,    4'b0100, 1, 33'd8,         1'b0, 1'b0};
    vecs[8]  = '{"code15",  1'b1, 17'd1,     17'd1,     4'b1111, 0, 33'd0,         1'b0, 1'b1};
    vecs[9]  = '{"shl",     1'b0, 17'h1FFFD, 17'd0,     4'b0111, 1, 33'h1FFFFFFFA, 1'b0, 1'b0};
    vecs[10] = '{"not",     1'b0, 17'd0,     17'd0,     4'b1000, 1, 33'h1FFFFFFFF, 1'b0, 1'b0};
    vecs[11] = '{"code9",   1'b1, 17'd4,     17'd2,     4'b1001, 0, 33'd0,         1'b0, 1'b1};

    reset_n = 1'b0;
    req_a   = 1'b1;
    req_b   = 1'b0;
    a_op1   = 17'd0;
    a_op2   = 17'd0;
    b_op1   = 17'd0;
    b_op2   = 17'd0;
    a_ctrl  = 4'd0;
    b_ctrl  = 4'd0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset outputs",
                64'({gnt_a, gnt_b, done_a, done_b, sign, err, busy, alu_ctrl}),
                64'({7'b0000000, 4'b1111}));
    checkOutput("reset data", 64'({result, alu_op1, alu_op2}), 64'd0);
    req_a = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] tie from reset");
    applyStimulus(1'b0, 17'd1, 17'd2, 4'b0000);
    applyStimulus(1'b1, 17'd10, 17'd3, 4'b0001);
    runTransaction("tieA", 1'b0, 1, 17'd1, 17'd2, 4'b0000, 33'd3, 1'b0, 1'b0);
    runTransaction("tieB", 1'b1, 1, 17'd10, 17'd3, 4'b0001, 33'd7, 1'b0, 1'b0);

    $display("[TB] directed table");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].useB, vecs[i].op1, vecs[i].op2, vecs[i].ctrl);
      runTransaction(vecs[i].name, vecs[i].useB, vecs[i].expN, vecs[i].op1, vecs[i].op2,
                     vecs[i].ctrl, vecs[i].expRes, vecs[i].expSign, vecs[i].expErr);
    end

    $display("[TB] random transactions");
    for (int i = 0; i < 40; i++) begin
      if (!req_a && $urandom_range(0, 1) == 1) randomRequest(1'b0);
      if (!req_b && $urandom_range(0, 1) == 1) randomRequest(1'b1);
      if (!req_a && !req_b) randomRequest(1'($urandom_range(0, 1)));
      winB = (req_a && req_b) ? ~lastGrantB : req_b;
      if (winB) begin
        o1 = b_op1;
        o2 = b_op2;
        c  = b_ctrl;
      end else begin
        o1 = a_op1;
        o2 = a_op2;
        c  = a_ctrl;
      end
      refModel(o1, o2, c, n, r, s, e);
      runTransaction($sformatf("rand%0d", i), winB, n, o1, o2, c, r, s, e);
    end
    req_a = 1'b0;
    req_b = 1'b0;

    $display("[TB] reset during divide");
    applyStimulus(1'b0, 17'd20, 17'd22, 4'b0000);
    runTransaction("preAdd", 1'b0, 1, 17'd20, 17'd22, 4'b0000, 33'd42, 1'b0, 1'b0);
    applyStimulus(1'b0, 17'd100, 17'd5, 4'b0010);
    @(negedge clk);
    checkOutput("abort gnt", 64'({gnt_a, gnt_b}), 64'd2);
    @(posedge clk);
    #1;
    req_a = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort exec2", 64'({busy, alu_ctrl}), 64'({1'b1, 4'b0010}));
    reset_n = 1'b0;
    #1;
    checkOutput("abort state",
                64'({busy, done_a, done_b, sign, err, alu_ctrl, alu_op1, alu_op2}),
                64'({5'b00000, 4'b1111, 17'd0, 17'd0}));
    checkOutput("abort result", 64'(result), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput($sformatf("abort quiet%0d", i), 64'({done_a, done_b, busy}), 64'd0);
    end
    @(posedge clk);
    #1;
    lastGrantB = 1'b1;
    applyStimulus(1'b0, 17'd6, 17'd1, 4'b0001);
    applyStimulus(1'b1, 17'd2, 17'd3, 4'b0011);
    runTransaction("postA", 1'b0, 1, 17'd6, 17'd1, 4'b0001, 33'd5, 1'b0, 1'b0);
    runTransaction("postB", 1'b1, 2, 17'd2, 17'd3, 4'b0011, 33'd6, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
